// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle signals of the RV32I decode stage.
// master: upstream/downstream side; slave: the decode stage itself.
interface decode_stage_if #(
  parameter int unsigned ALU_W = 6,
  parameter int unsigned CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ALU_W-1:0]  alu_cnt;
  logic              reg_wr;
  logic              mem_to_reg;
  logic              mem_rd;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [2:0]        br_type;
  logic              lui_cnt;
  logic              illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_instr, alu_cnt, reg_wr, mem_to_reg,
           mem_rd, mem_wr, mem_size, mem_unsigned, br_type, lui_cnt,
           illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_instr, alu_cnt, reg_wr, mem_to_reg,
           mem_rd, mem_wr, mem_size, mem_unsigned, br_type, lui_cnt,
           illegal, illegal_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a two-entry skid buffer.
// Optional M-extension decode is enabled by defining DECODE_MULDIV_EN.
module decode_stage #(
  parameter int unsigned ALU_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             reg_wr;
    logic             mem_to_reg;
    logic             mem_rd;
    logic             mem_wr;
    logic [1:0]       mem_size;
    logic             mem_unsigned;
    logic [2:0]       br_type;
    logic             lui;
    logic             illegal;
  } ctrl_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [31:0]      instr0_q, instr1_q;
  ctrl_t            ctl0_q, ctl1_q;
  logic [CNT_W-1:0] cnt_q;

  ctrl_t      dec_d;
  logic       ill;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       accept;
  logic       handoff;

  assign opcode  = bus.in_instr[6:0];
  assign f3      = bus.in_instr[14:12];
  assign f7      = bus.in_instr[31:25];
  assign accept  = bus.in_valid & in_ready_q;
  assign handoff = out_valid_q & bus.out_ready;

  always_comb begin
    dec_d = '0;
    ill   = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        dec_d.reg_wr = 1'b1;
        if (f7 == 7'h00) begin
          unique case (f3)
            3'b000: dec_d.alu = ALU_W'(1);
            3'b001: dec_d.alu = ALU_W'(3);
            3'b010: dec_d.alu = ALU_W'(4);
            3'b011: dec_d.alu = ALU_W'(5);
            3'b100: dec_d.alu = ALU_W'(6);
            3'b101: dec_d.alu = ALU_W'(7);
            3'b110: dec_d.alu = ALU_W'(9);
            default: dec_d.alu = ALU_W'(10);
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) begin
          dec_d.alu = ALU_W'(2);
        end else if (f7 == 7'h20 && f3 == 3'b101) begin
          dec_d.alu = ALU_W'(8);
`ifdef DECODE_MULDIV_EN
        end else if (f7 == 7'h01) begin
          dec_d.alu = ALU_W'(6'd40 + {3'b000, f3});
`endif
        end else begin
          ill = 1'b1;
        end
      end
      7'b0010011: begin
        dec_d.reg_wr = 1'b1;
        unique case (f3)
          3'b000: dec_d.alu = ALU_W'(11);
          3'b001: begin
            dec_d.alu = ALU_W'(12);
            ill       = (f7 != 7'h00);
          end
          3'b010: dec_d.alu = ALU_W'(13);
          3'b011: dec_d.alu = ALU_W'(14);
          3'b100: dec_d.alu = ALU_W'(15);
          3'b101: begin
            if (f7 == 7'h00)      dec_d.alu = ALU_W'(16);
            else if (f7 == 7'h20) dec_d.alu = ALU_W'(19);
            else                  ill = 1'b1;
          end
          3'b110: dec_d.alu = ALU_W'(17);
          default: dec_d.alu = ALU_W'(18);
        endcase
      end
      7'b0000011: begin
        dec_d.reg_wr     = 1'b1;
        dec_d.mem_rd     = 1'b1;
        dec_d.mem_to_reg = 1'b1;
        dec_d.mem_size   = f3[1:0];
        dec_d.mem_unsigned = f3[2];
        unique case (f3)
          3'b000: dec_d.alu = ALU_W'(20);
          3'b001: dec_d.alu = ALU_W'(21);
          3'b010: dec_d.alu = ALU_W'(22);
          3'b100: dec_d.alu = ALU_W'(23);
          3'b101: dec_d.alu = ALU_W'(24);
          default: ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_d.mem_wr   = 1'b1;
        dec_d.mem_size = f3[1:0];
        unique case (f3)
          3'b000: dec_d.alu = ALU_W'(25);
          3'b001: dec_d.alu = ALU_W'(26);
          3'b010: dec_d.alu = ALU_W'(27);
          default: ill = 1'b1;
        endcase
      end
      7'b1100011: begin
        unique case (f3)
          3'b000: begin dec_d.alu = ALU_W'(28); dec_d.br_type = 3'd1; end
          3'b001: begin dec_d.alu = ALU_W'(29); dec_d.br_type = 3'd2; end
          3'b100: begin dec_d.alu = ALU_W'(30); dec_d.br_type = 3'd3; end
          3'b101: begin dec_d.alu = ALU_W'(31); dec_d.br_type = 3'd4; end
          3'b110: begin dec_d.alu = ALU_W'(32); dec_d.br_type = 3'd5; end
          3'b111: begin dec_d.alu = ALU_W'(33); dec_d.br_type = 3'd6; end
          default: ill = 1'b1;
        endcase
      end
      7'b0110111: begin
        dec_d.alu    = ALU_W'(34);
        dec_d.lui    = 1'b1;
        dec_d.reg_wr = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // Illegal encodings carry no controls at all, only the flag.
    if (ill) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      instr0_q    <= '0;
      instr1_q    <= '0;
      ctl0_q      <= '0;
      ctl1_q      <= '0;
      cnt_q       <= '0;
    end else if (flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      if (handoff && ctl0_q.illegal && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            instr0_q    <= bus.in_instr;
            ctl0_q      <= dec_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && !handoff) begin
            instr1_q   <= bus.in_instr;
            ctl1_q     <= dec_d;
            in_ready_q <= 1'b0;
            state_q    <= TWO;
          end else if (!accept && handoff) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end else if (accept && handoff) begin
            instr0_q <= bus.in_instr;
            ctl0_q   <= dec_d;
          end
        end
        TWO: begin
          if (handoff) begin
            instr0_q   <= instr1_q;
            ctl0_q     <= ctl1_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = instr0_q;
  assign bus.alu_cnt      = ctl0_q.alu;
  assign bus.reg_wr       = ctl0_q.reg_wr;
  assign bus.mem_to_reg   = ctl0_q.mem_to_reg;
  assign bus.mem_rd       = ctl0_q.mem_rd;
  assign bus.mem_wr       = ctl0_q.mem_wr;
  assign bus.mem_size     = ctl0_q.mem_size;
  assign bus.mem_unsigned = ctl0_q.mem_unsigned;
  assign bus.br_type      = ctl0_q.br_type;
  assign bus.lui_cnt      = ctl0_q.lui;
  assign bus.illegal      = ctl0_q.illegal;
  assign bus.illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus back-pressure,
// counter saturation (CNT_W=2 twin), flush and asynchronous reset sequences.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.ALU_W(6), .CNT_W(16)) bus ();
  decode_stage_if #(.ALU_W(6), .CNT_W(2))  bus2 ();

  decode_stage #(.ALU_W(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );
  decode_stage #(.ALU_W(6), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.out_ready = bus.out_ready;

  typedef struct packed {
    logic [31:0] instr;
    logic [5:0]  alu;
    logic        rw;
    logic        m2r;
    logic        mrd;
    logic        mwr;
    logic [1:0]  sz;
    logic        uns;
    logic [2:0]  br;
    logic        lui;
    logic        ill;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] act_ctl();
    return {bus.alu_cnt, bus.reg_wr, bus.mem_to_reg, bus.mem_rd, bus.mem_wr,
            bus.mem_size, bus.mem_unsigned, bus.br_type, bus.lui_cnt, bus.illegal};
  endfunction

  function automatic logic [17:0] exp_ctl(input vec_t v);
    return {v.alu, v.rw, v.m2r, v.mrd, v.mwr, v.sz, v.uns, v.br, v.lui, v.ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string name);
    check({name, " cnt"}, 32'(bus.illegal_cnt), 32'(exp_cnt));
    check({name, " satcnt"}, 32'(bus2.illegal_cnt), 32'((exp_cnt > 3) ? 3 : exp_cnt));
  endtask

  initial begin
    //            instr         alu    rw m2r mrd mwr sz    uns br    lui ill
    vecs[0]  = '{32'h002081B3, 6'd1,  1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0}; // add
    vecs[1]  = '{32'h40208133, 6'd2,  1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0}; // sub
    vecs[2]  = '{32'h0000A183, 6'd22, 1, 1, 1, 0, 2'd2, 0, 3'd0, 0, 0}; // lw
    vecs[3]  = '{32'h0020A063, 6'd0,  0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1}; // branch f3=010
    vecs[4]  = '{32'hFFFFFFFF, 6'd0,  0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1};
`ifdef DECODE_MULDIV_EN
    vecs[5]  = '{32'h02208133, 6'd40, 1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0}; // mul
`else
    vecs[5]  = '{32'h02208133, 6'd0,  0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1};
`endif
    vecs[6]  = '{32'h00208023, 6'd25, 0, 0, 0, 1, 2'd0, 0, 3'd0, 0, 0}; // sb
    vecs[7]  = '{32'h00209063, 6'd29, 0, 0, 0, 0, 2'd0, 0, 3'd2, 0, 0}; // bne
    vecs[8]  = '{32'h0000C183, 6'd23, 1, 1, 1, 0, 2'd0, 1, 3'd0, 0, 0}; // lbu
    vecs[9]  = '{32'h4030D093, 6'd19, 1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0}; // srai
    vecs[10] = '{32'h00001093, 6'd12, 1, 0, 0, 0, 2'd0, 0, 3'd0, 0, 0}; // slli
    vecs[11] = '{32'h02001093, 6'd0,  0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1}; // slli bad f7
    vecs[12] = '{32'h123450B7, 6'd34, 1, 0, 0, 0, 2'd0, 0, 3'd0, 1, 0}; // lui
    vecs[13] = '{32'h0000B183, 6'd0,  0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1}; // load f3=011
    vecs[14] = '{32'h0000F063, 6'd33, 0, 0, 0, 0, 2'd0, 0, 3'd6, 0, 0}; // bgeu
    vecs[15] = '{32'h0000E023, 6'd0,  0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1}; // store f3=110
    vecs[16] = '{32'h40209033, 6'd0,  0, 0, 0, 0, 2'd0, 0, 3'd0, 0, 1}; // f7=0x20 f3=001

    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    check("rst out_valid", 32'(bus.out_valid), 0);
    check("rst ctrl", 32'(act_ctl()), 0);
    check("rst out_instr", bus.out_instr, 0);
    rst = 1'b0;
    step();
    check("rst in_ready", 32'(bus.in_ready), 1);
    check_cnt("rst");

    // Back-to-back vector stream, out_ready held high
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = vecs[i].instr;
      step();
      check($sformatf("vec%0d valid", i), 32'(bus.out_valid), 1);
      check($sformatf("vec%0d ready", i), 32'(bus.in_ready), 1);
      check($sformatf("vec%0d ctrl", i), 32'(act_ctl()), 32'(exp_ctl(vecs[i])));
      check($sformatf("vec%0d instr", i), bus.out_instr, vecs[i].instr);
      check_cnt($sformatf("vec%0d", i));
      if (vecs[i].ill) exp_cnt++;
    end
    bus.in_valid = 1'b0;
    step();
    check("drain valid", 32'(bus.out_valid), 0);
    check_cnt("drain");

    // Back-pressure: two entries buffered, released in order
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h40208133;
    step();
    check("bp1 ready", 32'(bus.in_ready), 1);
    check("bp1 alu", 32'(bus.alu_cnt), 2);
    bus.in_instr = 32'h0000A183;
    step();
    check("bp2 ready", 32'(bus.in_ready), 0);
    check("bp2 held alu", 32'(bus.alu_cnt), 2);
    bus.in_valid = 1'b0;
    step();
    check("bp3 held valid", 32'(bus.out_valid), 1);
    check("bp3 held instr", bus.out_instr, 32'h40208133);
    bus.out_ready = 1'b1;
    step();
    check("bp4 valid", 32'(bus.out_valid), 1);
    check("bp4 ctrl", 32'(act_ctl()), 32'(exp_ctl(vecs[2])));
    check("bp4 ready", 32'(bus.in_ready), 1);
    step();
    check("bp5 valid", 32'(bus.out_valid), 0);
    check_cnt("bp");

    // Flush with two illegal bundles buffered and a new offer
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hFFFFFFFF;
    step();
    step();
    check("fl pre ready", 32'(bus.in_ready), 0);
    flush        = 1'b1;
    bus.in_instr = 32'h002081B3;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl valid", 32'(bus.out_valid), 0);
    check("fl ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    step();
    check("fl post valid", 32'(bus.out_valid), 0);
    check_cnt("fl");

    // Asynchronous reset between edges
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0000A183;
    step();
    bus.in_valid = 1'b0;
    check("ar pre valid", 32'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("ar valid", 32'(bus.out_valid), 0);
    check("ar ctrl", 32'(act_ctl()), 0);
    check("ar instr", bus.out_instr, 0);
    check_cnt("ar");
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("ar rel ready", 32'(bus.in_ready), 1);
    check("ar rel valid", 32'(bus.out_valid), 0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0000E093; // ori
    step();
    bus.in_valid = 1'b0;
    check("ar ori valid", 32'(bus.out_valid), 1);
    check("ar ori alu", 32'(bus.alu_cnt), 17);
    check("ar ori rw", 32'(bus.reg_wr), 1);
    step();
    check("ar ori gone", 32'(bus.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised instruction decoder for the RV32I core, sitting between instruction fetch and register read/execute. Accepts 32-bit instructions over a valid/ready handshake and decodes opcode/funct3/funct7 into a registered control bundle. A two-entry skid buffer keeps full throughput under back-pressure. Also flags illegal encodings, counts them, and supports pipeline flush.

## Interface
- ALU_W, 6, width of alu_cnt; must be ≥6
- CNT_W, 16, width of illegal-instruction counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous: discard all buffered instructions
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction of the current bundle
- alu_cnt  out  ALU_W  ALU operation code; 0 = none/illegal
- reg_wr  out  1  writes rd
- mem_to_reg  out  1  load result to rd
- mem_rd, mem_wr  out  1 each  load / store
- mem_size  out  2  0 byte, 1 half, 2 word
- mem_unsigned  out  1  LBU/LHU
- br_type  out  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU
- lui_cnt  out  1  LUI
- illegal  out  1  encoding not supported
- illegal_cnt  out  CNT_W  saturating count of illegal bundles handed off

## Operation
- alu_cnt codes: ADD 1, SUB 2, SLL 3, SLT 4, SLTU 5, XOR 6, SRL 7, SRA 8, OR 9, AND 10; ADDI 11, SLLI 12, SLTI 13, SLTIU 14, XORI 15, SRLI 16, ORI 17, ANDI 18, SRAI 19; LB 20, LH 21, LW 22, LBU 23, LHU 24; SB 25, SH 26, SW 27; BEQ 28, BNE 29, BLT 30, BGE 31, BLTU 32, BGEU 33; LUI 34; MUL..REMU 40..47 (funct3 order).
- R-type (0110011): funct7 0x00 all funct3; 0x20 only with funct3 000/101; else illegal.
- I-ALU (0010011): SLLI requires funct7 0x00; funct3 101 with funct7 0x00 → SRLI, 0x20 → SRAI, else illegal.
- Loads (0000011): funct3 000,001,010,100,101; others illegal. mem_rd=1, mem_to_reg=1, reg_wr=1.
- Stores (0100011): funct3 000,001,010; mem_wr=1, reg_wr=0.
- Branches (1100011): funct3 010/011 illegal; reg_wr=0.
- LUI (0110111): lui_cnt=1, reg_wr=1.
- Any other opcode, or illegal case: illegal=1, alu_cnt=0, all other controls 0; out_instr still passed.
- Buffer: output register (entry 0) plus skid register (entry 1). States EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE: accept without handoff → TWO; handoff without accept → EMPTY; both → ONE.
  - TWO: in_ready=0; handoff → ONE, skid moves to output.
- Transfer on in_valid&in_ready / out_valid&out_ready.
- illegal_cnt increments on handoff of a bundle with illegal=1; saturates at all-ones.

## Timing
- Latency 1 cycle: instruction accepted at edge N appears with out_valid=1 after edge N.
- in_ready = (state != TWO), registered; no combinational path out_ready→in_ready.
- Bundle held stable while out_valid=1 and out_ready=0.
- Back-to-back throughput 1 instruction/cycle with out_ready held high.
- flush: state → EMPTY next edge; accept in that cycle is dropped; illegal_cnt not incremented by flushed bundles; flush wins over all other events.
- Reset (any time, incl. mid-transfer): state EMPTY, out_valid=0, in_ready=1 (after release), all control outputs 0, out_instr=0, illegal_cnt=0.

## Configuration
- DECODE_MULDIV_EN defined: R-type funct7 0x01 decodes MUL..REMU to codes 40..47, reg_wr=1.
- Undefined: funct7 0x01 is illegal; codes 40..47 never produced; decode logic for them absent.

## Test plan
- Reset then 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, alu_cnt=1, reg_wr=1, illegal=0.
- out_ready=0, offer 0x40208133 (sub), then 0x0000A183 (lw) → both accepted, in_ready=0 after second; release out_ready → sub(2) then lw(22, mem_size=2, mem_to_reg=1) in order, no loss.
- 0x0020A063 (funct3 010 branch) then 0xFFFFFFFF → illegal=1, alu_cnt=0; illegal_cnt=2 after both handoffs; preload CNT_W=2 with 4 illegal → stays 3.
- 0x02208133 (mul) → with DECODE_MULDIV_EN alu_cnt=40; without, illegal=1.
- TWO entries buffered, assert flush one cycle with in_valid=1 → out_valid=0, in_ready=1, nothing emitted, illegal_cnt unchanged.
- rst asserted mid-stream asynchronously (between edges) → outputs 0 immediately; after release first new instruction decodes with 1-cycle latency.
